// File: rtl/regfile_param_if.sv
// Register-file port bundle: writeback port, decode read ports, clear control, debug read.
interface regfile_param_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned NREAD = 2
);
   logic                    we;
   logic [AW-1:0]           waddr;
   logic [XLEN-1:0]         wdata;
   logic [NREAD*AW-1:0]     raddr;
   logic [NREAD*XLEN-1:0]   rdata;
   logic                    clr_req;
   logic                    busy;
   logic                    wr_err;
   logic [AW-1:0]           dbg_addr;
   logic [XLEN-1:0]         dbg_data;

   modport master (
      output we, waddr, wdata, raddr, clr_req, dbg_addr,
      input  rdata, busy, wr_err, dbg_data
   );

   modport slave (
      input  we, waddr, wdata, raddr, clr_req, dbg_addr,
      output rdata, busy, wr_err, dbg_data
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised integer register file: x0 reads zero, one write port, NREAD
// combinational read ports, optional write-to-read forwarding, a sequenced
// bulk-clear engine and a one-cycle dropped-write flag.
module regfile_param #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned AW     = 5,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned BYPASS = 1
) (
   input  logic           clk,
   input  logic           rst,
   regfile_param_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t          state;
   state_t          state_nx;
   logic [AW-1:0]   cnt;
   logic [AW-1:0]   cnt_nx;
   logic            wr_err_q;
   logic            wr_err_nx;
   logic            in_range;
   logic            wr_ok;
   logic [XLEN-1:0] regs [1:NREGS-1];

   // An index beyond the implemented set aliases nothing; x0 is not stored.
   assign in_range = (32'(bus.waddr) < NREGS);
   assign wr_ok    = bus.we && (state == IDLE) && in_range && (bus.waddr != '0);

   assign bus.busy   = (state == CLEAR);
   assign bus.wr_err = wr_err_q;

   // Next state, clear-sweep index and dropped-write detection.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      wr_err_nx = bus.we && (!in_range || (state == CLEAR));
      case (state)
         IDLE: begin
            if (bus.clr_req) begin
               state_nx = CLEAR;
               cnt_nx   = AW'(1);
            end
         end
         CLEAR: begin
            if (cnt == LAST_IDX) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + AW'(1);
            end
         end
      endcase
   end

   // Control state; reset aborts any sweep in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         wr_err_q <= wr_err_nx;
      end
   end

   for (genvar r = 1; r < NREGS; r++) begin : g_reg
      // One register: the clear sweep wins, otherwise an accepted write lands.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            regs[r] <= '0;
         end else if ((state == CLEAR) && (cnt == AW'(r))) begin
            regs[r] <= '0;
         end else if (wr_ok && (bus.waddr == AW'(r))) begin
            regs[r] <= bus.wdata;
         end
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;

      assign ra = bus.raddr[p*AW +: AW];

      // Register select for this port, forwarding an accepted same-cycle write.
      always_comb begin
         rd = '0;
         for (int unsigned i = 1; i < NREGS; i++) begin
            if (ra == AW'(i)) rd = regs[i];
         end
         if ((BYPASS != 0) && wr_ok && (bus.waddr == ra)) rd = bus.wdata;
      end

      assign bus.rdata[p*XLEN +: XLEN] = rd;
   end

   logic [XLEN-1:0] dbg_rd;

   // Debug view of stored contents only; never forwarded.
   always_comb begin
      dbg_rd = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         if (bus.dbg_addr == AW'(i)) dbg_rd = regs[i];
      end
   end

   assign bus.dbg_data = dbg_rd;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 16x32 two-port forwarding instance and a 32x32
// three-port non-forwarding instance driven with identical stimulus and
// checked against a per-instance array model.
module tb_regfile_param;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_param_if #(.XLEN(32), .AW(5), .NREAD(2)) bus0 ();
   regfile_param_if #(.XLEN(32), .AW(5), .NREAD(3)) bus1 ();

   regfile_param u0 (.clk(clk), .rst(rst), .bus(bus0));
   regfile_param #(.XLEN(32), .NREGS(32), .AW(5), .NREAD(3), .BYPASS(0))
      u1 (.clk(clk), .rst(rst), .bus(bus1));

   logic        we;
   logic        clr_req;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  dbg_addr;
   logic [4:0]  ra [3];

   assign bus0.we = we;           assign bus1.we = we;
   assign bus0.waddr = waddr;     assign bus1.waddr = waddr;
   assign bus0.wdata = wdata;     assign bus1.wdata = wdata;
   assign bus0.clr_req = clr_req; assign bus1.clr_req = clr_req;
   assign bus0.dbg_addr = dbg_addr; assign bus1.dbg_addr = dbg_addr;
   assign bus0.raddr = {ra[1], ra[0]};
   assign bus1.raddr = {ra[2], ra[1], ra[0]};

   // Reference model: register contents, remaining clear sweep and error pulse.
   int unsigned nr [2] = '{16, 32};
   bit          byp [2] = '{1'b1, 1'b0};
   logic [31:0] m [2][32];
   int unsigned age [2];
   bit          err [2];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) m[d][i] = '0;
         age[d] = 0;
         err[d] = 1'b0;
      end
   endtask

   // Effect of one rising edge with the current inputs.
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit e;
         e = we && ((32'(waddr) >= nr[d]) || (age[d] != 0));
         if (age[d] != 0) begin
            m[d][age[d]] = '0;
            age[d] = (age[d] == nr[d] - 1) ? 0 : age[d] + 1;
         end else begin
            if (we && waddr != 0 && 32'(waddr) < nr[d]) m[d][waddr] = wdata;
            if (clr_req) age[d] = 1;
         end
         err[d] = e;
      end
   endtask

   function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
      if (a == 0 || 32'(a) >= nr[d]) return '0;
      if (byp[d] && age[d] == 0 && we && waddr == a) return wdata;
      return m[d][a];
   endfunction

   function automatic logic [31:0] exp_dbg(int d, logic [4:0] a);
      return (32'(a) >= nr[d]) ? 32'h0 : m[d][a];
   endfunction

   function automatic logic [95:0] exp_vec(int d);
      logic [95:0] v;
      v = '0;
      for (int p = 0; p < 2 + d; p++) v[p*32 +: 32] = exp_rd(d, ra[p]);
      return v;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0; dbg_addr = '0;
      for (int p = 0; p < 3; p++) ra[p] = '0;
   endtask

   task automatic load_regs(int unsigned base);
      for (int i = 1; i < 16; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = 32'(i) + 32'(base);
         tick();
      end
      we = 1'b0;
   endtask

   task automatic test_reset();
      for (int a = 0; a < 32; a++) begin
         ra[0] = 5'(a); ra[1] = 5'(31 - a); ra[2] = 5'(a + 9); dbg_addr = 5'(a);
         #1;
         n_cmp++;
         if (bus0.rdata !== 64'h0 || bus1.rdata !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_read a=%0d got %h / %h want 0", a, bus0.rdata, bus1.rdata);
         end
         n_cmp++;
         if (bus0.dbg_data !== 32'h0 || bus1.dbg_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_dbg a=%0d got %h / %h want 0", a, bus0.dbg_data, bus1.dbg_data);
         end
         tick();
      end
      n_cmp++;
      if ({bus0.busy, bus0.wr_err, bus1.busy, bus1.wr_err} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 0000",
                  {bus0.busy, bus0.wr_err, bus1.busy, bus1.wr_err});
      end
      set_idle();
   endtask

   task automatic test_bypass();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      ra[0] = 5'd5; ra[1] = 5'd0; ra[2] = 5'd5; dbg_addr = 5'd5;
      #1;
      n_cmp++;
      if (bus0.rdata[31:0] !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL bypass_on got %h want deadbeef", bus0.rdata[31:0]);
      end
      n_cmp++;
      if (bus1.rdata[31:0] !== 32'h0 || bus1.rdata[95:64] !== 32'h0) begin
         n_bad++; $display("FAIL bypass_off got %h want 0", bus1.rdata);
      end
      n_cmp++;
      if (bus0.dbg_data !== 32'h0) begin
         n_bad++; $display("FAIL dbg_no_bypass got %h want 0", bus0.dbg_data);
      end
      tick();
      we = 1'b0;
      #1;
      n_cmp++;
      if (bus0.rdata[31:0] !== 32'hDEADBEEF || bus1.rdata[31:0] !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL write_latency got %h / %h want deadbeef", bus0.rdata[31:0], bus1.rdata[31:0]);
      end
      n_cmp++;
      if (bus0.dbg_data !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL dbg_read got %h want deadbeef", bus0.dbg_data);
      end
      tick();
      set_idle();
   endtask

   task automatic test_x0_oob();
      we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
      tick();
      we = 1'b0; ra[0] = 5'd0; ra[1] = 5'd20; ra[2] = 5'd20;
      #1;
      n_cmp++;
      if (bus0.wr_err !== 1'b0 || bus1.wr_err !== 1'b0) begin
         n_bad++; $display("FAIL x0_no_err got %b/%b want 0/0", bus0.wr_err, bus1.wr_err);
      end
      n_cmp++;
      if (bus0.rdata !== 64'h0 || bus1.rdata[31:0] !== 32'h0) begin
         n_bad++; $display("FAIL x0_read got %h / %h want 0", bus0.rdata, bus1.rdata[31:0]);
      end
      we = 1'b1; waddr = 5'd20;
      tick();
      we = 1'b0;
      #1;
      n_cmp++;
      if (bus0.wr_err !== 1'b1 || bus1.wr_err !== 1'b0) begin
         n_bad++; $display("FAIL oob_err got %b/%b want 1/0", bus0.wr_err, bus1.wr_err);
      end
      n_cmp++;
      if (bus0.rdata[63:32] !== 32'h0 || bus1.rdata[63:32] !== 32'h1234) begin
         n_bad++;
         $display("FAIL oob_read got %h / %h want 0 / 1234", bus0.rdata[63:32], bus1.rdata[63:32]);
      end
      tick();
      n_cmp++;
      if (bus0.wr_err !== 1'b0) begin
         n_bad++; $display("FAIL oob_err_pulse got %b want 0", bus0.wr_err);
      end
      set_idle();
   endtask

   task automatic test_clear();
      logic [31:0] x3;
      logic [31:0] x15;
      load_regs(0);
      clr_req = 1'b1; ra[0] = 5'd3; ra[1] = 5'd15; ra[2] = 5'd3;
      tick();
      clr_req = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         we = (k == 8); waddr = 5'd3; wdata = 32'd77;
         #1;
         x3  = (k > 3)  ? 32'h0 : 32'd3;
         x15 = (k > 15) ? 32'h0 : 32'd15;
         n_cmp++;
         if (bus0.busy !== (k <= 15) || bus1.busy !== (k <= 31)) begin
            n_bad++; $display("FAIL clear_busy k=%0d got %b/%b", k, bus0.busy, bus1.busy);
         end
         n_cmp++;
         if (bus0.rdata !== {x15, x3} || bus1.rdata[31:0] !== x3) begin
            n_bad++;
            $display("FAIL clear_read k=%0d got %h / %h want %h", k, bus0.rdata, bus1.rdata[31:0], {x15, x3});
         end
         n_cmp++;
         if (bus0.wr_err !== (k == 9) || bus1.wr_err !== (k == 9)) begin
            n_bad++; $display("FAIL clear_wr_err k=%0d got %b/%b", k, bus0.wr_err, bus1.wr_err);
         end
         tick();
      end
      set_idle();
      for (int a = 1; a < 32; a++) begin
         ra[0] = 5'(a); ra[1] = 5'(a); ra[2] = 5'(a); dbg_addr = 5'(a);
         #1;
         n_cmp++;
         if (bus0.rdata !== 64'h0 || bus1.rdata !== 96'h0 || bus1.dbg_data !== 32'h0) begin
            n_bad++; $display("FAIL clear_done a=%0d got %h / %h", a, bus0.rdata, bus1.rdata);
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_clear_reissue();
      int b0;
      int b1;
      b0 = 0; b1 = 0;
      load_regs(100);
      clr_req = 1'b1;
      tick();
      for (int c = 1; c <= 60; c++) begin
         clr_req = (c == 4);
         #1;
         if (bus0.busy === 1'b1) b0++;
         if (bus1.busy === 1'b1) b1++;
         tick();
      end
      clr_req = 1'b0;
      n_cmp++;
      if (b0 != 15) begin
         n_bad++; $display("FAIL reissue_busy16 got %0d want 15", b0);
      end
      n_cmp++;
      if (b1 != 31) begin
         n_bad++; $display("FAIL reissue_busy32 got %0d want 31", b1);
      end
      set_idle();
   endtask

   task automatic test_reset_mid();
      load_regs(200);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 1; c <= 6; c++) tick();
      ra[0] = 5'd9; ra[1] = 5'd14; ra[2] = 5'd12;
      #1;
      n_cmp++;
      if (bus0.busy !== 1'b1 || bus0.rdata[63:32] !== 32'd214) begin
         n_bad++; $display("FAIL mid_before got busy=%b x14=%h want 1/d6", bus0.busy, bus0.rdata[63:32]);
      end
      rst = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({bus0.busy, bus1.busy, bus0.wr_err, bus1.wr_err} !== 4'b0) begin
         n_bad++; $display("FAIL mid_reset_flags got %b want 0000",
                           {bus0.busy, bus1.busy, bus0.wr_err, bus1.wr_err});
      end
      n_cmp++;
      if (bus0.rdata !== 64'h0 || bus1.rdata !== 96'h0) begin
         n_bad++; $display("FAIL mid_reset_read got %h / %h want 0", bus0.rdata, bus1.rdata);
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
      tick();
      we = 1'b0;
      #1;
      n_cmp++;
      if (bus0.rdata !== {32'h0, 32'hA5A5A5A5} || bus1.rdata[63:0] !== {32'h0, 32'hA5A5A5A5}) begin
         n_bad++; $display("FAIL post_reset_write got %h / %h", bus0.rdata, bus1.rdata[63:0]);
      end
      tick();
      set_idle();
   endtask

   task automatic test_random();
      logic [95:0] e0;
      logic [95:0] e1;
      for (int n = 0; n < 600; n++) begin
         we = 1'($urandom_range(0, 1));
         waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         clr_req = ($urandom_range(0, 39) == 0);
         for (int p = 0; p < 3; p++) ra[p] = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 2) == 0) ra[0] = waddr;
         dbg_addr = 5'($urandom_range(0, 31));
         #1;
         e0 = exp_vec(0);
         e1 = exp_vec(1);
         n_cmp++;
         if (bus0.rdata !== e0[63:0]) begin
            n_bad++; $display("FAIL rand_rd16 n=%0d got %h want %h", n, bus0.rdata, e0[63:0]);
         end
         n_cmp++;
         if (bus1.rdata !== e1) begin
            n_bad++; $display("FAIL rand_rd32 n=%0d got %h want %h", n, bus1.rdata, e1);
         end
         n_cmp++;
         if (bus0.dbg_data !== exp_dbg(0, dbg_addr) || bus1.dbg_data !== exp_dbg(1, dbg_addr)) begin
            n_bad++;
            $display("FAIL rand_dbg n=%0d got %h / %h want %h / %h", n, bus0.dbg_data,
                     bus1.dbg_data, exp_dbg(0, dbg_addr), exp_dbg(1, dbg_addr));
         end
         n_cmp++;
         if ({bus0.busy, bus0.wr_err, bus1.busy, bus1.wr_err} !==
             {age[0] != 0, err[0], age[1] != 0, err[1]}) begin
            n_bad++;
            $display("FAIL rand_flags n=%0d got %b want %b", n,
                     {bus0.busy, bus0.wr_err, bus1.busy, bus1.wr_err},
                     {age[0] != 0, err[0], age[1] != 0, err[1]});
         end
         tick();
      end
      set_idle();
      repeat (40) tick();
      n_cmp++;
      if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
         n_bad++; $display("FAIL rand_drain got %b/%b want 0/0", bus0.busy, bus1.busy);
      end
   endtask

   initial begin
      rst = 1'b0;
      set_idle();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_bypass();
      test_x0_oob();
      test_clear();
      test_clear_reissue();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
